// File: rtl/regfile_param.sv
// Parametrised multi-port register file: two prioritised write ports, optional
// write-to-read bypass and a hardware clear sequencer that zeroes one register per cycle.
module regfile_param #(
    parameter int  DW        = 16,
    parameter int  DEPTH     = 8,
    parameter int  NREAD     = 2,
    parameter bit  ZERO_REG0 = 1'b1,
    parameter bit  BYPASS    = 1'b1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREAD*AW-1:0] ra,
    output logic [NREAD*DW-1:0] rd,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [DW-1:0]       wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [DW-1:0]       wd1,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t        state_r;
    logic [AW-1:0] ptr_r;
    logic [DW-1:0] regs_r [DEPTH];
    logic          idle_s;
    logic          wr0_s;
    logic          wr1_s;

    // Write qualification: only while idle, never into a hardwired R0, port 1 wins a collision
    always_comb begin
        idle_s = (state_r == ST_IDLE);
        wr1_s  = idle_s && we1 && !(ZERO_REG0 && (wa1 == {AW{1'b0}}));
        wr0_s  = idle_s && we0 && !(ZERO_REG0 && (wa0 == {AW{1'b0}}))
                 && !(wr1_s && (wa1 == wa0));
    end

    // Clear sequencer with registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            ptr_r    <= {AW{1'b0}};
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ptr_r    <= {AW{1'b0}};
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state_r  <= ST_CLEAR;
                        clr_busy <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                        clr_busy <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    ptr_r    <= ptr_r + PTR_ONE;
                    clr_busy <= 1'b1;
                    if (ptr_r == LAST_PTR) begin
                        state_r  <= ST_DONE;
                        clr_done <= 1'b1;
                    end else begin
                        state_r  <= ST_CLEAR;
                        clr_done <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r  <= ST_IDLE;
                    ptr_r    <= {AW{1'b0}};
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    ptr_r    <= {AW{1'b0}};
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: sequenced clear takes precedence over (and suppresses) normal writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DW{1'b0}};
            end
        end else if (state_r == ST_CLEAR) begin
            regs_r[ptr_r] <= {DW{1'b0}};
        end else begin
            if (wr0_s) begin
                regs_r[wa0] <= wd0;
            end
            if (wr1_s) begin
                regs_r[wa1] <= wd1;
            end
        end
    end

    // Combinational read ports: hardwired R0, then bypass from port 1, port 0, then storage
    always_comb begin
        rd = {(NREAD*DW){1'b0}};
        for (int i = 0; i < NREAD; i++) begin
            if (ZERO_REG0 && (ra[i*AW +: AW] == {AW{1'b0}})) begin
                rd[i*DW +: DW] = {DW{1'b0}};
            end else if (BYPASS && idle_s && we1 && (wa1 == ra[i*AW +: AW])) begin
                rd[i*DW +: DW] = wd1;
            end else if (BYPASS && idle_s && we0 && (wa0 == ra[i*AW +: AW])) begin
                rd[i*DW +: DW] = wd0;
            end else begin
                rd[i*DW +: DW] = regs_r[ra[i*AW +: AW]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// array-based reference model for the default, ZERO_REG0=0 and wide/4-port builds.
module tb_regfile_param;

    logic        clk;
    logic        rst;
    logic [5:0]  ra;
    logic [31:0] rd;
    logic [31:0] rd_z;
    logic        we0, we1, clr_req;
    logic [2:0]  wa0, wa1;
    logic [15:0] wd0, wd1;
    logic        busy, done, busy_z, done_z;

    logic [15:0]  b_ra;
    logic [127:0] b_rd;
    logic         b_we0, b_we1, b_clr_req, b_busy, b_done;
    logic [3:0]   b_wa0, b_wa1;
    logic [31:0]  b_wd0, b_wd1;

    logic [15:0] m  [8];
    logic [15:0] mz [8];
    logic [31:0] mb [16];

    int n_tests = 0;
    int n_fail  = 0;

    regfile_param u_dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .clr_req(clr_req), .clr_busy(busy), .clr_done(done)
    );

    regfile_param #(.ZERO_REG0(1'b0)) u_z0 (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_z),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .clr_req(clr_req), .clr_busy(busy_z), .clr_done(done_z)
    );

    regfile_param #(.DW(32), .DEPTH(16), .NREAD(4)) u_big (
        .clk(clk), .rst(rst), .ra(b_ra), .rd(b_rd),
        .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0), .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
        .clr_req(b_clr_req), .clr_busy(b_busy), .clr_done(b_done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
    endtask

    task automatic model_zero();
        for (int i = 0; i < 8; i++) begin
            m[i] = 16'h0000; mz[i] = 16'h0000;
        end
        for (int i = 0; i < 16; i++) mb[i] = 32'h0;
    endtask

    // Called after the edge that latched the currently driven write inputs
    task automatic model_commit();
        if (we0 && wa0 != 3'd0) m[wa0] = wd0;
        if (we1 && wa1 != 3'd0) m[wa1] = wd1;
        if (we0) mz[wa0] = wd0;
        if (we1) mz[wa1] = wd1;
    endtask

    function automatic logic [15:0] exp_rd(input int a, input bit hardzero);
        if (hardzero && a == 0) return 16'h0000;
        else if (we1 && int'(wa1) == a) return wd1;
        else if (we0 && int'(wa0) == a) return wd0;
        else if (hardzero) return m[a];
        else return mz[a];
    endfunction

    function automatic logic [31:0] exp_big(input int a);
        if (a == 0) return 32'h0;
        else if (b_we1 && int'(b_wa1) == a) return b_wd1;
        else if (b_we0 && int'(b_wa0) == a) return b_wd0;
        else return mb[a];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got busy=%b done=%b expected 0 0", busy, done);
        end
        for (int r = 0; r < 8; r++) begin
            ra = {3'(7 - r), 3'(r)};
            #1;
            n_tests++;
            if (rd !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read_r%0d: got %h expected 00000000", r, rd);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        we0 = 1'b1; wa0 = 3'd3; wd0 = 16'hBEEF;
        tick();
        model_commit();
        idle_inputs();
        for (int r = 0; r < 8; r++) begin
            logic [15:0] exp;
            exp = (r == 3) ? 16'hBEEF : 16'h0000;
            ra = {3'(r), 3'(r)};
            #1;
            n_tests++;
            if (rd[15:0] !== exp || rd[31:16] !== exp) begin
                n_fail++;
                $display("FAIL write_read_r%0d: got %h expected %h on both ports", r, rd, exp);
            end
        end
    endtask

    task automatic test_dual_write();
        we0 = 1'b1; wa0 = 3'd5; wd0 = 16'h1111;
        we1 = 1'b1; wa1 = 3'd5; wd1 = 16'h2222;
        ra = {3'd3, 3'd5};
        #1;
        n_tests++;
        if (rd !== {16'hBEEF, 16'h2222}) begin
            n_fail++;
            $display("FAIL dual_bypass: got %h expected beef2222", rd);
        end
        tick();
        model_commit();
        idle_inputs();
        ra = {3'd5, 3'd5};
        #1;
        n_tests++;
        if (rd !== {16'h2222, 16'h2222}) begin
            n_fail++;
            $display("FAIL dual_stored: got %h expected 22222222", rd);
        end
        we0 = 1'b1; wa0 = 3'd6; wd0 = 16'h3333;
        we1 = 1'b1; wa1 = 3'd7; wd1 = 16'h4444;
        ra = {3'd7, 3'd6};
        #1;
        n_tests++;
        if (rd !== {16'h4444, 16'h3333}) begin
            n_fail++;
            $display("FAIL split_bypass: got %h expected 44443333", rd);
        end
        tick();
        model_commit();
        idle_inputs();
        #1;
        n_tests++;
        if (rd !== {16'h4444, 16'h3333}) begin
            n_fail++;
            $display("FAIL split_stored: got %h expected 44443333", rd);
        end
    endtask

    task automatic test_zero_reg0();
        we0 = 1'b1; wa0 = 3'd0; wd0 = 16'hFFFF;
        ra = {3'd0, 3'd0};
        #1;
        n_tests++;
        if (rd[15:0] !== 16'h0000 || rd_z[15:0] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL r0_bypass: got zero=%h plain=%h expected 0000 ffff", rd[15:0], rd_z[15:0]);
        end
        tick();
        model_commit();
        idle_inputs();
        #1;
        n_tests++;
        if (rd[15:0] !== 16'h0000 || rd_z[15:0] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL r0_stored: got zero=%h plain=%h expected 0000 ffff", rd[15:0], rd_z[15:0]);
        end
    endtask

    task automatic test_random_default(input int n);
        for (int k = 0; k < n; k++) begin
            we0 = 1'($urandom_range(0, 1)); wa0 = 3'($urandom_range(0, 7)); wd0 = 16'($urandom);
            we1 = 1'($urandom_range(0, 1)); wa1 = 3'($urandom_range(0, 7)); wd1 = 16'($urandom);
            ra  = 6'($urandom_range(0, 63));
            #1;
            n_tests++;
            if (rd[15:0] !== exp_rd(int'(ra[2:0]), 1'b1) || rd[31:16] !== exp_rd(int'(ra[5:3]), 1'b1)) begin
                n_fail++;
                $display("FAIL rand_default_%0d: got %h expected %h%h", k, rd,
                         exp_rd(int'(ra[5:3]), 1'b1), exp_rd(int'(ra[2:0]), 1'b1));
            end
            n_tests++;
            if (rd_z[15:0] !== exp_rd(int'(ra[2:0]), 1'b0) || rd_z[31:16] !== exp_rd(int'(ra[5:3]), 1'b0)) begin
                n_fail++;
                $display("FAIL rand_plain_r0_%0d: got %h expected %h%h", k, rd_z,
                         exp_rd(int'(ra[5:3]), 1'b0), exp_rd(int'(ra[2:0]), 1'b0));
            end
            tick();
            model_commit();
        end
        idle_inputs();
    endtask

    task automatic fill_regs();
        for (int r = 1; r < 8; r++) begin
            we0 = 1'b1; wa0 = 3'(r); wd0 = 16'($urandom) | 16'h0001;
            tick();
            model_commit();
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        fill_regs();
        clr_req = 1'b1;
        we0 = 1'b1; wa0 = 3'd2; wd0 = 16'hABCD;
        ra = {3'd2, 3'd2};
        #1;
        n_tests++;
        if (rd[15:0] !== 16'hABCD) begin
            n_fail++;
            $display("FAIL clear_req_bypass: got %h expected abcd", rd[15:0]);
        end
        tick();
        model_commit();
        idle_inputs();
        // c counts cycles after the edge that accepted clr_req
        for (int c = 1; c <= 11; c++) begin
            if (c == 3) begin
                we1 = 1'b1; wa1 = 3'd7; wd1 = 16'h5555;
                we0 = 1'b1; wa0 = 3'd6; wd0 = 16'h6666;
            end else begin
                we0 = 1'b0; we1 = 1'b0;
            end
            clr_req = (c == 5);
            n_tests++;
            if (busy !== (c <= 9) || done !== (c == 9)) begin
                n_fail++;
                $display("FAIL clear_status_c%0d: got busy=%b done=%b expected %b %b",
                         c, busy, done, (c <= 9), (c == 9));
            end
            for (int r = 0; r < 8; r++) begin
                logic [15:0] exp;
                exp = (r == 0 || r <= c - 2) ? 16'h0000 : m[r];
                ra = {3'(r), 3'(r)};
                #1;
                n_tests++;
                if (rd[15:0] !== exp) begin
                    n_fail++;
                    $display("FAIL clear_read_c%0d_r%0d: got %h expected %h", c, r, rd[15:0], exp);
                end
            end
            tick();
        end
        idle_inputs();
        model_zero();
    endtask

    task automatic test_reset_mid_clear();
        fill_regs();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_clear_status: got busy=%b done=%b expected 0 0", busy, done);
        end
        for (int r = 0; r < 8; r++) begin
            ra = {3'(r), 3'(r)};
            #1;
            n_tests++;
            if (rd !== 32'h0 || rd_z !== 32'h0) begin
                n_fail++;
                $display("FAIL rst_mid_clear_r%0d: got %h %h expected 0", r, rd, rd_z);
            end
        end
        model_zero();
        tick();
        rst = 1'b0;
        we1 = 1'b1; wa1 = 3'd4; wd1 = 16'h1234;
        tick();
        model_commit();
        idle_inputs();
        ra = {3'd4, 3'd4};
        #1;
        n_tests++;
        if (rd !== {16'h1234, 16'h1234} || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL write_after_rst: got %h busy=%b expected 12341234 busy=0", rd, busy);
        end
    endtask

    task automatic test_big(input int n);
        b_clr_req = 1'b0;
        for (int k = 0; k < n; k++) begin
            int base, step;
            int addr [4];
            b_we0 = 1'($urandom_range(0, 1)); b_wa0 = 4'($urandom_range(0, 15)); b_wd0 = $urandom;
            b_we1 = 1'($urandom_range(0, 1)); b_wa1 = 4'($urandom_range(0, 15)); b_wd1 = $urandom;
            base = int'($urandom_range(0, 15));
            step = 2 * int'($urandom_range(0, 7)) + 1;
            for (int i = 0; i < 4; i++) begin
                addr[i] = (base + i * step) % 16;
                b_ra[i*4 +: 4] = 4'(addr[i]);
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (b_rd[i*32 +: 32] !== exp_big(addr[i])) begin
                    n_fail++;
                    $display("FAIL big_%0d_port%0d: got %h expected %h", k, i, b_rd[i*32 +: 32], exp_big(addr[i]));
                end
            end
            tick();
            if (b_we0 && b_wa0 != 4'd0) mb[b_wa0] = b_wd0;
            if (b_we1 && b_wa1 != 4'd0) mb[b_wa1] = b_wd1;
        end
        b_we0 = 1'b0; b_we1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ra = 6'd0; wa0 = 3'd0; wa1 = 3'd0; wd0 = 16'h0; wd1 = 16'h0;
        idle_inputs();
        b_ra = 16'h0; b_we0 = 1'b0; b_we1 = 1'b0; b_clr_req = 1'b0;
        b_wa0 = 4'd0; b_wa1 = 4'd0; b_wd0 = 32'h0; b_wd1 = 32'h0;
        model_zero();
        test_reset();
        test_write_read();
        test_dual_write();
        test_zero_reg0();
        test_random_default(300);
        test_clear();
        test_random_default(50);
        test_reset_mid_clear();
        test_big(1000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
